// File: rtl/irq_ctrl_if.sv
// Interrupt bus between device lines / core trap logic and irq_ctrl.
// master = devices + core (drive requests, ack, mret), slave = the controller.
interface irq_ctrl_if #(
    parameter int N = 16
);
    logic [N-1:0] int_req_i;
    logic [N-1:0] mie_i;
    logic         int_ack_i;
    logic         int_rst_i;
    logic         int_o;
    logic [31:0]  mcause_o;
    logic [N-1:0] int_fin_o;

    // int_req_i is a level held until int_fin_o; int_ack_i and int_rst_i are
    // single-cycle pulses; int_o stays high until acked or withdrawn.
    modport master (
        output int_req_i, mie_i, int_ack_i, int_rst_i,
        input  int_o, mcause_o, int_fin_o
    );

    modport slave (
        input  int_req_i, mie_i, int_ack_i, int_rst_i,
        output int_o, mcause_o, int_fin_o
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: masks level requests, presents one to the core, pulses int_fin on mret.
// Define IRQ_CTRL_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index-first.
module irq_ctrl #(
    parameter int N          = 16,
    parameter int CAUSE_BASE = 16
) (
    input  logic         clk,
    input  logic         rstn,
    irq_ctrl_if.slave    bus,
    output logic [1:0]   dbg_state
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] sel_q, sel_d;
    logic            int_q, int_d;
    logic [31:0]     mcause_q, mcause_d;
    logic [N-1:0]    fin_q, fin_d;
    logic [N-1:0]    pend;
    logic [IDXW-1:0] win;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [IDXW-1:0] last_q, last_d;
`endif

    assign pend = bus.int_req_i & bus.mie_i;

    // Winner search; only meaningful when pend != 0.
    always_comb begin
        int   idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            idx = (int'(last_q) + 1 + k) % N;
`else
            idx = k;
`endif
            if (!found && pend[IDXW'(idx)]) begin
                win   = IDXW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        int_d    = int_q;
        mcause_d = mcause_q;
        fin_d    = '0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                int_d = 1'b0;
                if (pend != '0) begin
                    sel_d    = win;
                    mcause_d = {1'b1, 31'(CAUSE_BASE + int'(win))};
                    int_d    = 1'b1;
                    state_d  = PEND;
                end
            end
            PEND: begin
                // Ack wins over a withdrawal seen in the same cycle.
                if (bus.int_ack_i) begin
                    int_d   = 1'b0;
                    state_d = SERV;
                end else if (!pend[sel_q]) begin
                    int_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SERV: begin
                int_d = 1'b0;
                if (bus.int_rst_i) begin
                    fin_d[sel_q] = 1'b1;
                    state_d      = FIN;
                end
            end
            FIN: begin
                int_d   = 1'b0;
                state_d = IDLE;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
                last_d  = sel_q;
`endif
            end
            default: begin
                int_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            int_q    <= 1'b0;
            mcause_q <= '0;
            fin_q    <= '0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            last_q   <= IDXW'(N - 1);
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            int_q    <= int_d;
            mcause_q <= mcause_d;
            fin_q    <= fin_d;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    assign bus.int_o     = int_q;
    assign bus.mcause_o  = mcause_q;
    assign bus.int_fin_o = fin_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized checks of irq_ctrl against a transaction-level priority model.
module tb_irq_ctrl;
    localparam int N = 16;

    logic       clk;
    logic       rstn;
    logic [1:0] dbg_state;
    int         total;
    int         bad;
    int         last_m;
    int         gap;
    logic [31:0] exp_q[$];

    irq_ctrl_if #(.N(N)) bus ();

    irq_ctrl #(.N(N), .CAUSE_BASE(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference priority: first set bit of p scanning from last_m+1 (rotating) or from 0 (fixed).
    function automatic int pick(input logic [N-1:0] p);
        int idx;
        for (int k = 0; k < N; k++) begin
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            idx = (last_m + 1 + k) % N;
`else
            idx = k;
`endif
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [31:0] cause(input int k);
        return 32'h8000_0000 | 32'(16 + k);
    endfunction

    // Full handshake for whatever the model says should win; device clears its request on fin.
    task automatic serve(input string tag, input int hold, input int work);
        int k;
        int c;
        k = pick(bus.int_req_i & bus.mie_i);
        exp_q.push_back(cause(k));
        c = 0;
        while (bus.int_o !== 1'b1 && c < 8) begin
            step();
            c++;
        end
        check({tag, "_int_up"}, 64'(bus.int_o), 64'd1);
        check({tag, "_cause"}, 64'(bus.mcause_o), 64'(exp_q.pop_front()));
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, "_int_hold"}, 64'(bus.int_o), 64'd1);
        end
        bus.int_ack_i = 1'b1;
        step();
        bus.int_ack_i = 1'b0;
        check({tag, "_int_down"}, 64'(bus.int_o), 64'd0);
        for (int w = 0; w < work; w++) begin
            step();
            check({tag, "_serv_quiet"}, 64'({bus.int_o, bus.int_fin_o}), 64'd0);
        end
        bus.int_rst_i = 1'b1;
        step();
        bus.int_rst_i = 1'b0;
        check({tag, "_fin"}, 64'(bus.int_fin_o), 64'(16'(1) << k));
        bus.int_req_i[k] = 1'b0;
        last_m = k;
        step();
        check({tag, "_fin_off"}, 64'(bus.int_fin_o), 64'd0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        last_m = N - 1;
        rstn          = 1'b0;
        bus.int_req_i = '0;
        bus.mie_i     = 16'hFFFF;
        bus.int_ack_i = 1'b0;
        bus.int_rst_i = 1'b0;
        step();
        step();
        rstn = 1'b1;

        // Reset / idle
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_int", 64'(bus.int_o), 64'd0);
            check("idle_cause", 64'(bus.mcause_o), 64'd0);
            check("idle_fin", 64'(bus.int_fin_o), 64'd0);
        end

        // Single source, explicit latency
        bus.int_req_i[3] = 1'b1;
        step();
        check("single_int", 64'(bus.int_o), 64'd1);
        check("single_cause", 64'(bus.mcause_o), 64'h8000_0013);
        bus.int_ack_i = 1'b1;
        step();
        bus.int_ack_i = 1'b0;
        check("single_ack", 64'(bus.int_o), 64'd0);
        bus.int_rst_i = 1'b1;
        step();
        bus.int_rst_i = 1'b0;
        check("single_fin", 64'(bus.int_fin_o), 64'h0008);
        bus.int_req_i[3] = 1'b0;
        last_m = 3;
        step();
        check("single_fin_once", 64'(bus.int_fin_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("single_after", 64'(bus.int_o), 64'd0);
            check("single_cause_kept", 64'(bus.mcause_o), 64'h8000_0013);
        end

        // Priority between 2 and 5, and the turnaround after fin
        bus.int_req_i = (16'(1) << 5) | (16'(1) << 2);
        serve("prio_a", 0, 0);
        check("prio_gap0", 64'(bus.int_o), 64'd0);
        step();
        check("prio_gap2", 64'(bus.int_o), 64'd1);
        serve("prio_b", 0, 0);

        // Mask / withdraw
        bus.int_req_i[7] = 1'b1;
        bus.mie_i[7]     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mask_int", 64'(bus.int_o), 64'd0);
        end
        bus.mie_i[7] = 1'b1;
        step();
        check("unmask_int", 64'(bus.int_o), 64'd1);
        check("unmask_cause", 64'(bus.mcause_o), 64'(cause(7)));
        bus.mie_i[7] = 1'b0;
        step();
        check("withdraw_int", 64'(bus.int_o), 64'd0);
        check("withdraw_fin", 64'(bus.int_fin_o), 64'd0);
        check("withdraw_state", 64'(dbg_state), 64'd0);
        step();
        check("withdraw_stay", 64'(bus.int_o), 64'd0);
        bus.int_req_i[7] = 1'b0;
        bus.mie_i        = 16'hFFFF;

        // mret in IDLE is ignored
        bus.int_rst_i = 1'b1;
        step();
        bus.int_rst_i = 1'b0;
        check("idle_rst_fin", 64'(bus.int_fin_o), 64'd0);
        check("idle_rst_state", 64'(dbg_state), 64'd0);
        step();
        check("idle_rst_fin2", 64'(bus.int_fin_o), 64'd0);

        // Second ack in SERV is ignored
        bus.int_req_i[1] = 1'b1;
        step();
        check("nest_int", 64'(bus.int_o), 64'd1);
        bus.int_ack_i = 1'b1;
        step();
        check("nest_serv", 64'(dbg_state), 64'd2);
        step();
        bus.int_ack_i = 1'b0;
        check("nest_ack2_int", 64'(bus.int_o), 64'd0);
        check("nest_ack2_state", 64'(dbg_state), 64'd2);
        check("nest_ack2_fin", 64'(bus.int_fin_o), 64'd0);
        bus.int_rst_i = 1'b1;
        step();
        bus.int_rst_i = 1'b0;
        check("nest_fin", 64'(bus.int_fin_o), 64'h0002);
        bus.int_req_i[1] = 1'b0;
        last_m = 1;
        step();

        // Ack and withdrawal in the same PEND cycle
        bus.int_req_i[4] = 1'b1;
        step();
        check("race_int", 64'(bus.int_o), 64'd1);
        bus.int_ack_i    = 1'b1;
        bus.int_req_i[4] = 1'b0;
        step();
        bus.int_ack_i = 1'b0;
        check("race_state", 64'(dbg_state), 64'd2);
        check("race_int_down", 64'(bus.int_o), 64'd0);
        bus.int_rst_i = 1'b1;
        step();
        bus.int_rst_i = 1'b0;
        check("race_fin", 64'(bus.int_fin_o), 64'h0010);
        last_m = 4;
        step();

        // Asynchronous reset in SERV
        bus.int_req_i[3] = 1'b1;
        step();
        bus.int_ack_i = 1'b1;
        step();
        bus.int_ack_i = 1'b0;
        check("arst_pre_state", 64'(dbg_state), 64'd2);
        #2 rstn = 1'b0;
        #1;
        check("arst_int", 64'(bus.int_o), 64'd0);
        check("arst_state", 64'(dbg_state), 64'd0);
        check("arst_cause", 64'(bus.mcause_o), 64'd0);
        last_m = N - 1;
        step();
        rstn = 1'b1;
        step();
        check("arst_re_int", 64'(bus.int_o), 64'd1);
        check("arst_re_cause", 64'(bus.mcause_o), 64'h8000_0013);
        serve("arst_re", 0, 0);

        // Randomized request sets against the priority model
        for (int r = 0; r < 30; r++) begin
            bus.mie_i     = 16'($urandom) | 16'($urandom);
            bus.int_req_i = 16'($urandom);
            for (int s = 0; s < N + 1; s++) begin
                if ((bus.int_req_i & bus.mie_i) == '0) break;
                serve("rand", $urandom_range(0, 3), $urandom_range(0, 3));
            end
            bus.int_req_i = '0;
            step();
            check("rand_idle", 64'(bus.int_o), 64'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller between the peripheral interrupt lines and the core trap logic.
- Collects level requests (int_req) from up to N bus devices, masks them, and selects one.
- Raises a single interrupt to the core with the matching mcause value.
- When the core executes mret, returns a one-cycle int_fin pulse to the served device, which then clears its request.

Parameters:
- N, default 16, number of interrupt sources (2..32).
- CAUSE_BASE, default 16, mcause code of source 0; source k reports CAUSE_BASE+k.

Ports:
- clk  in  1  system clock, the same clock as the bus.
- rstn  in  1  reset, asynchronous, active-low.
- int_req_i  in  N  level requests from devices; each is held high until that device's int_fin.
- mie_i  in  N  per-source enable from the CSR unit.
- int_ack_i  in  1  one-cycle pulse from the core: the trap was taken for the presented interrupt.
- int_rst_i  in  1  one-cycle pulse from the core: mret executed, handler done.
- int_o  out  1  interrupt request to the core.
- mcause_o  out  32  cause for the presented interrupt: {1'b1, 31'(CAUSE_BASE+idx)}.
- int_fin_o  out  N  one-hot, one-cycle completion pulse to the served device.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, int_o=0, mcause_o=0, int_fin_o=0, sel=0, last=N-1. All outputs are registered.
- pend = int_req_i & mie_i.
- Selection (base): the lowest set index of pend wins.
- FSM states: IDLE, PEND, SERV, FIN.
- IDLE:
  - If pend!=0, latch sel=winner, set mcause_o and int_o=1, go to PEND.
  - int_o rises one cycle after pend is seen.
- PEND:
  - int_o is held at 1.
  - If int_ack_i=1, go to SERV and drop int_o to 0 on the next edge.
  - Otherwise, if pend[sel]=0 (request withdrawn or masked), drop int_o and return to IDLE with no int_fin.
  - int_ack_i has priority over withdrawal in the same cycle.
  - A higher-priority request arriving in PEND does not preempt sel.
- SERV:
  - int_o=0; changes to pend are ignored.
  - On int_rst_i=1, go to FIN.
  - int_ack_i in SERV is ignored (no nesting).
- FIN:
  - int_fin_o[sel]=1 for exactly this one cycle, then IDLE. Set last=sel.
  - The device clears int_req on the edge that ends FIN, so IDLE never re-samples the stale request.
- int_rst_i in IDLE or PEND is ignored: no int_fin, no state change.
- mcause_o holds its value from selection until the next selection; it is not cleared in SERV or FIN.
- Minimum turnaround: request to int_o is 1 cycle; int_rst_i to int_fin_o is 1 cycle; int_fin_o to the next int_o is at least 2 cycles.
- Reset asserted in any state returns to IDLE immediately. Any int_fin pulse in flight is lost; the device keeps its request and is re-served after reset.
- N=32 with CAUSE_BASE+idx: the sum is truncated to 31 bits, with no overflow check.

Optional Feature:
- Macro IRQ_CTRL_ROUND_ROBIN_EN.
- Defined: the search starts at index (last+1) mod N and wraps around; the first set bit of pend in that order wins. After reset last=N-1, so the first search starts at 0. A source served last has the lowest priority next time.
- Undefined: fixed priority, lowest index wins. The last register is not implemented.

Test Plan:
- Reset/idle:
  - Stimulus: rstn=0, then release with int_req_i=0.
  - Required: int_o=0, mcause_o=0, int_fin_o=0 for 10 cycles.
- Single source, full handshake:
  - Stimulus: N=16; req[3]=1, mie=0xFFFF.
  - Required: int_o=1 next cycle with mcause_o=0x8000_0013.
  - Stimulus: int_ack pulse.
  - Required: int_o=0.
  - Stimulus: int_rst pulse.
  - Required: int_fin_o=0x0008 for exactly 1 cycle. With the device model clearing req, int_o stays 0 afterwards.
- Fixed priority:
  - Stimulus: req[5] and req[2] rise together.
  - Required: source 2 is served first (mcause 0x8000_0012), then source 5 (0x8000_0015) with no gap beyond 2 cycles after fin.
  - Required with IRQ_CTRL_ROUND_ROBIN_EN and last=2: source 5 wins over 2.
- Mask/withdraw:
  - Stimulus: req[7]=1 with mie[7]=0.
  - Required: int_o stays 0.
  - Stimulus: enable mie[7], then clear it while in PEND (before ack).
  - Required: int_o drops, int_fin_o stays 0, FSM returns to IDLE.
- Ignored events:
  - Stimulus: int_rst pulse in IDLE.
  - Required: no int_fin.
  - Stimulus: second int_ack in SERV.
  - Required: no effect.
  - Stimulus: int_ack and withdrawal in the same PEND cycle.
  - Required: enters SERV.
- Reset mid-service:
  - Stimulus: assert rstn=0 asynchronously (between clock edges) in SERV.
  - Required: int_o=0 and state IDLE without waiting for a clock edge.
  - Stimulus: release reset with req[3] still high.
  - Required: source 3 is re-presented with mcause 0x8000_0013.
